// File: rtl/tile_cmd_writer.sv
// rtl/tile_cmd_writer.sv - LCD init sequencer and grid-tile writer on an 8080 parallel bus
module tile_cmd_writer #(
  parameter int CELL       = 20,
  parameter int WAKE_DELAY = 1000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       cs_n,
  output logic       dc,
  output logic       wr_n,
  output logic [7:0] data
);

  localparam int PIX_N = CELL * CELL;
  localparam int PW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int WW    = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
  // Grid has 12 rows; requests at or below this row are acknowledged without drawing.
  localparam logic [3:0] ROWS = 4'd12;

  typedef enum logic [3:0] {
    S_INIT_SEND,
    S_INIT_WAIT,
    S_INIT_ON,
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_PIXEL,
    S_DONE
  } state_t;

  state_t        state, state_n, follow;
  logic          phase, phase_n;
  logic [2:0]    byte_cnt, byte_n;
  logic [PW-1:0] pix_cnt, pix_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic          run;
  logic [3:0]    x_q, y_q;
  logic [2:0]    obj_q;
  logic          skip, on_bus, last_byte;
  logic [15:0]   x0, x1, y0, y1, colour;
  logic [8:0]    cur;

  assign skip = (y_q >= ROWS);
  assign x0   = 16'(x_q) * 16'(CELL);
  assign x1   = x0 + 16'(CELL - 1);
  assign y0   = 16'(y_q) * 16'(CELL);
  assign y1   = y0 + 16'(CELL - 1);

  // State and counters; run holds the bus quiet for the first cycle after reset so
  // byte 0 of the init sequence still gets a full write-low phase.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      run      <= 1'b0;
      state    <= S_INIT_SEND;
      phase    <= 1'b0;
      byte_cnt <= '0;
      pix_cnt  <= '0;
      wait_cnt <= '0;
      x_q      <= '0;
      y_q      <= '0;
      obj_q    <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      byte_cnt <= byte_n;
      pix_cnt  <= pix_n;
      wait_cnt <= wait_n;
      if (state == S_IDLE && diff) begin
        x_q   <= x;
        y_q   <= y;
        obj_q <= obj_code;
      end
    end
  end

  // Where each byte sequence ends and which state follows it.
  always_comb begin
    last_byte = 1'b0;
    follow    = state;
    case (state)
      S_INIT_SEND: begin last_byte = (byte_cnt == 3'd2); follow = S_INIT_WAIT; end
      S_INIT_ON:   begin last_byte = 1'b1;               follow = S_DONE;      end
      S_CASET:     begin last_byte = (byte_cnt == 3'd4); follow = S_PASET;     end
      S_PASET:     begin last_byte = (byte_cnt == 3'd4); follow = S_RAMWR;     end
      S_RAMWR:     begin last_byte = 1'b1;               follow = S_PIXEL;     end
      S_PIXEL: begin
        last_byte = byte_cnt[0] && (pix_cnt == PW'(PIX_N - 1));
        follow    = S_DONE;
      end
      default: ;
    endcase
  end

  // Next-state: two-phase byte engine, wake delay count, request accept.
  always_comb begin
    state_n = state;
    phase_n = phase;
    byte_n  = byte_cnt;
    pix_n   = pix_cnt;
    wait_n  = wait_cnt;
    case (state)
      S_INIT_WAIT: begin
        if (wait_cnt == WW'(WAKE_DELAY - 1)) begin
          state_n = S_INIT_ON;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_IDLE: if (diff) state_n = S_CASET;
      S_DONE: state_n = S_IDLE;
      default: begin
        if (state == S_CASET && skip) begin
          state_n = S_DONE;
        end else if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (last_byte) begin
            state_n = follow;
            byte_n  = '0;
            pix_n   = '0;
          end else if (state == S_PIXEL) begin
            byte_n = {2'b00, ~byte_cnt[0]};
            if (byte_cnt[0]) pix_n = pix_cnt + 1'b1;
          end else begin
            byte_n = byte_cnt + 3'd1;
          end
        end
      end
    endcase
  end

  // RGB565 colour of the latched object.
  always_comb begin
    case (obj_q)
      3'd0:    colour = 16'h0000;
      3'd1:    colour = 16'h07E0;
      3'd2:    colour = 16'hFFE0;
      3'd3:    colour = 16'hF800;
      3'd4:    colour = 16'h8410;
      default: colour = 16'hFFFF;
    endcase
  end

  // Current byte as {dc, data}.
  always_comb begin
    cur = 9'h000;
    case (state)
      S_INIT_SEND: begin
        case (byte_cnt)
          3'd0:    cur = 9'h03A;
          3'd1:    cur = 9'h155;
          default: cur = 9'h011;
        endcase
      end
      S_INIT_ON: cur = 9'h029;
      S_CASET: begin
        case (byte_cnt)
          3'd0:    cur = 9'h02A;
          3'd1:    cur = {1'b1, x0[15:8]};
          3'd2:    cur = {1'b1, x0[7:0]};
          3'd3:    cur = {1'b1, x1[15:8]};
          default: cur = {1'b1, x1[7:0]};
        endcase
      end
      S_PASET: begin
        case (byte_cnt)
          3'd0:    cur = 9'h02B;
          3'd1:    cur = {1'b1, y0[15:8]};
          3'd2:    cur = {1'b1, y0[7:0]};
          3'd3:    cur = {1'b1, y1[15:8]};
          default: cur = {1'b1, y1[7:0]};
        endcase
      end
      S_RAMWR: cur = 9'h02C;
      S_PIXEL: cur = byte_cnt[0] ? {1'b1, colour[7:0]} : {1'b1, colour[15:8]};
      default: cur = 9'h000;
    endcase
  end

  // Bus drive: selected only while a byte sequence is running.
  always_comb begin
    on_bus = 1'b0;
    case (state)
      S_INIT_SEND, S_INIT_ON, S_PASET, S_RAMWR, S_PIXEL: on_bus = run;
      S_CASET: on_bus = run && !skip;
      default: on_bus = 1'b0;
    endcase
    cs_n     = !on_bus;
    wr_n     = !(on_bus && !phase);
    dc       = on_bus && cur[8];
    data     = on_bus ? cur[7:0] : 8'h00;
    busy     = (state != S_IDLE);
    cmd_done = (state == S_DONE);
  end

endmodule
